// File: rtl/reg_file_mp_if.sv
// Register file access bundle: one write port, NUM_RD read ports,
// plus the array clear request/status handshake.
interface reg_file_mp_if #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2
) ();
  logic                     wr_en;
  logic [ADDR_W-1:0]        wr_addr;
  logic [WIDTH-1:0]         wr_data;
  logic [NUM_RD-1:0]        rd_en;
  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*WIDTH-1:0]  rd_data;
  logic [NUM_RD-1:0]        rd_valid;
  logic                     clr_req;
  logic                     busy;
  logic                     clr_done;

  modport master (
    output wr_en, wr_addr, wr_data,
    output rd_en, rd_addr, clr_req,
    input  rd_data, rd_valid,
    input  busy, clr_done
  );

  modport slave (
    input  wr_en, wr_addr, wr_data,
    input  rd_en, rd_addr, clr_req,
    output rd_data, rd_valid,
    output busy, clr_done
  );
endinterface

// File: rtl/reg_file_mp.sv
// Multi-read-port register file with hardwired zero entry,
// optional write-to-read bypass and a one-entry-per-cycle clear sweep.
module reg_file_mp #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1
) (
  input logic         clk,
  input logic         rst,
  reg_file_mp_if.slave bus
);

  typedef enum logic {
    IDLE,
    CLEAR
  } state_t;

  localparam logic [ADDR_W:0] DEPTH_X =
    (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST =
    ADDR_W'(DEPTH-1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              done_q, done_d;
  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic              busy;
  logic              wr_ok;

  assign busy = (state_q == CLEAR);

  assign wr_ok = bus.wr_en && !busy &&
    ({1'b0, bus.wr_addr} < DEPTH_X) &&
    !(ZERO_REG && (bus.wr_addr == '0));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.clr_req) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      CLEAR: begin
        if (cnt_q == LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    endcase
  end

  // Array is not reset; the sweep owns the write port while busy.
  always_ff @(posedge clk) begin
    if (busy) begin
      mem_q[cnt_q] <= '0;
    end else if (wr_ok) begin
      mem_q[bus.wr_addr] <= bus.wr_data;
    end
  end

  assign bus.busy     = busy;
  assign bus.clr_done = done_q;

  for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic [WIDTH-1:0]  data_d, data_q;
    logic              valid_d, valid_q;

    assign ra = bus.rd_addr[g*ADDR_W +: ADDR_W];
    assign valid_d = bus.rd_en[g] && !busy;

    always_comb begin
      data_d = '0;
      if (({1'b0, ra} < DEPTH_X) &&
          !(ZERO_REG && (ra == '0))) begin
        if (BYPASS && wr_ok &&
            (bus.wr_addr == ra)) begin
          data_d = bus.wr_data;
        end else begin
          data_d = mem_q[ra];
        end
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        valid_q <= 1'b0;
        data_q  <= '0;
      end else begin
        valid_q <= valid_d;
        if (valid_d) begin
          data_q <= data_d;
        end
      end
    end

    assign bus.rd_valid[g] = valid_q;
    assign bus.rd_data[g*WIDTH +: WIDTH] = data_q;
  end

endmodule

// File: tb/tb_reg_file_mp.sv
// Bench for reg_file_mp: default, no-bypass and DEPTH=24 instances
// share one stimulus; a scoreboard checks the default instance.
module tb_reg_file_mp;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [1:0]  rd_en;
  logic [9:0]  rd_addr;
  logic        clr_req;

  reg_file_mp_if if0 ();
  reg_file_mp_if if1 ();
  reg_file_mp_if if2 ();

  assign if0.wr_en   = wr_en;
  assign if0.wr_addr = wr_addr;
  assign if0.wr_data = wr_data;
  assign if0.rd_en   = rd_en;
  assign if0.rd_addr = rd_addr;
  assign if0.clr_req = clr_req;
  assign if1.wr_en   = wr_en;
  assign if1.wr_addr = wr_addr;
  assign if1.wr_data = wr_data;
  assign if1.rd_en   = rd_en;
  assign if1.rd_addr = rd_addr;
  assign if1.clr_req = clr_req;
  assign if2.wr_en   = wr_en;
  assign if2.wr_addr = wr_addr;
  assign if2.wr_data = wr_data;
  assign if2.rd_en   = rd_en;
  assign if2.rd_addr = rd_addr;
  assign if2.clr_req = clr_req;

  reg_file_mp u0 (
    .clk(clk), .rst(rst), .bus(if0)
  );
  reg_file_mp #(.BYPASS(1'b0)) u1 (
    .clk(clk), .rst(rst), .bus(if1)
  );
  reg_file_mp #(.DEPTH(24)) u2 (
    .clk(clk), .rst(rst), .bus(if2)
  );

  typedef struct {
    logic [1:0]  v;
    logic [31:0] d0;
    logic [31:0] d1;
  } exp_t;

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [1:0]  re;
    logic [4:0]  a0;
    logic [4:0]  a1;
    logic [1:0]  ev;
    logic [31:0] e0;
    logic [31:0] e1;
  } vec_t;

  exp_t        sbq[$];
  vec_t        vt[7];
  logic [31:0] last0, last1;
  int          checks = 0;
  int          errors = 0;
  string       tag;

  task automatic chk(string name,
                     logic [63:0] got,
                     logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s/%s got=%0h exp=%0h",
               tag, name, got, exp);
    end
  endtask

  task automatic step(logic we, logic [4:0] wa,
                      logic [31:0] wd, logic [1:0] re,
                      logic [4:0] a0, logic [4:0] a1,
                      logic cr, logic [1:0] ev,
                      logic [31:0] e0, logic [31:0] e1);
    exp_t x;
    wr_en   = we;
    wr_addr = wa;
    wr_data = wd;
    rd_en   = re;
    rd_addr = {a1, a0};
    clr_req = cr;
    if (ev[0]) last0 = e0;
    if (ev[1]) last1 = e1;
    x.v  = ev;
    x.d0 = last0;
    x.d1 = last1;
    sbq.push_back(x);
    @(posedge clk);
    #1;
    x = sbq.pop_front();
    chk("rd_valid", 64'(if0.rd_valid), 64'(x.v));
    chk("rd_data0", 64'(if0.rd_data[31:0]), 64'(x.d0));
    chk("rd_data1", 64'(if0.rd_data[63:32]), 64'(x.d1));
  endtask

  task automatic idle_in();
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    rd_en   = '0;
    rd_addr = '0;
    clr_req = 1'b0;
  endtask

  task automatic measure();
    int b0 = 0, b1 = 0, b2 = 0;
    int d0 = 0, d2 = 0;
    int p0 = -1, p2 = -1;
    idle_in();
    for (int c = 0; c < 40; c++) begin
      b0 += int'(if0.busy);
      b1 += int'(if1.busy);
      b2 += int'(if2.busy);
      if (if0.clr_done) begin d0++; p0 = c; end
      if (if2.clr_done) begin d2++; p2 = c; end
      @(posedge clk);
      #1;
    end
    chk("busy_cycles0", 64'(b0), 64'd32);
    chk("busy_cycles1", 64'(b1), 64'd32);
    chk("busy_cycles24", 64'(b2), 64'd24);
    chk("done_pulses0", 64'(d0), 64'd1);
    chk("done_pulses24", 64'(d2), 64'd1);
    chk("done_at0", 64'(p0), 64'd32);
    chk("done_at24", 64'(p2), 64'd24);
  endtask

  task automatic sweep_zero();
    for (int a = 0; a < 32; a++) begin
      step(1'b0, 5'd0, 32'd0, 2'b11,
           5'(a), 5'(31 - a), 1'b0,
           2'b11, 32'd0, 32'd0);
    end
  endtask

  initial begin
    vt[0] = '{1'b1, 5'd5, 32'hDEADBEEF, 2'b00,
              5'd0, 5'd0, 2'b00, 32'd0, 32'd0};
    vt[1] = '{1'b0, 5'd0, 32'd0, 2'b11,
              5'd5, 5'd5, 2'b11,
              32'hDEADBEEF, 32'hDEADBEEF};
    vt[2] = '{1'b1, 5'd0, 32'h12345678, 2'b11,
              5'd0, 5'd5, 2'b11,
              32'd0, 32'hDEADBEEF};
    vt[3] = '{1'b0, 5'd0, 32'd0, 2'b11,
              5'd0, 5'd0, 2'b11, 32'd0, 32'd0};
    vt[4] = '{1'b1, 5'd7, 32'h1, 2'b00,
              5'd0, 5'd0, 2'b00, 32'd0, 32'd0};
    vt[5] = '{1'b0, 5'd0, 32'd0, 2'b01,
              5'd7, 5'd0, 2'b01, 32'h1, 32'd0};
    vt[6] = '{1'b1, 5'd7, 32'hA5A5A5A5, 2'b10,
              5'd0, 5'd7, 2'b10,
              32'd0, 32'hA5A5A5A5};

    idle_in();
    last0 = '0;
    last1 = '0;
    tag = "reset";
    #2 rst = 1'b1;
    #1;
    chk("rst_valid", 64'(if0.rd_valid), 64'd0);
    chk("rst_data", 64'(if0.rd_data), 64'd0);
    chk("rst_busy", 64'(if0.busy), 64'd1);
    chk("rst_done", 64'(if0.clr_done), 64'd0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    measure();
    sweep_zero();

    tag = "table";
    for (int i = 0; i < 7; i++) begin
      step(vt[i].we, vt[i].wa, vt[i].wd,
           vt[i].re, vt[i].a0, vt[i].a1, 1'b0,
           vt[i].ev, vt[i].e0, vt[i].e1);
    end
    chk("nobyp_valid", 64'(if1.rd_valid), 64'd2);
    chk("nobyp_data1",
        64'(if1.rd_data[63:32]), 64'h1);
    tag = "after_byp";
    step(1'b0, 5'd0, 32'd0, 2'b01, 5'd7, 5'd0,
         1'b0, 2'b01, 32'hA5A5A5A5, 32'd0);
    chk("nobyp_new",
        64'(if1.rd_data[31:0]), 64'hA5A5A5A5);

    tag = "oor";
    step(1'b1, 5'd30, 32'h77, 2'b01, 5'd30, 5'd0,
         1'b0, 2'b01, 32'h77, 32'd0);
    chk("d24_valid", 64'(if2.rd_valid[0]), 64'd1);
    chk("d24_byp", 64'(if2.rd_data[31:0]), 64'd0);
    step(1'b0, 5'd0, 32'd0, 2'b11, 5'd30, 5'd6,
         1'b0, 2'b11, 32'h77, 32'd0);
    chk("d24_rd30", 64'(if2.rd_data[31:0]), 64'd0);
    chk("d24_rd6", 64'(if2.rd_data[63:32]), 64'd0);

    tag = "fill";
    for (int a = 1; a < 32; a++) begin
      step(1'b1, 5'(a), 32'(a * 32'h11), 2'b00,
           5'd0, 5'd0, 1'b0, 2'b00, 32'd0, 32'd0);
    end
    step(1'b0, 5'd0, 32'd0, 2'b11, 5'd31, 5'd3,
         1'b0, 2'b11, 32'h20F, 32'h33);

    tag = "clear";
    step(1'b0, 5'd0, 32'd0, 2'b00, 5'd0, 5'd0,
         1'b1, 2'b00, 32'd0, 32'd0);
    for (int k = 0; k < 32; k++) begin
      step(1'b1, 5'd3, 32'hFF, 2'b11, 5'd3, 5'd31,
           k < 5, 2'b00, 32'd0, 32'd0);
      chk("clr_busy", 64'(if0.busy), 64'(k < 31));
      chk("clr_done", 64'(if0.clr_done),
          64'(k == 31));
    end
    tag = "post_clear";
    sweep_zero();

    tag = "rst_mid_read";
    step(1'b0, 5'd0, 32'd0, 2'b11, 5'd0, 5'd1,
         1'b0, 2'b11, 32'd0, 32'd0);
    rst = 1'b1;
    #1;
    chk("valid_cleared", 64'(if0.rd_valid), 64'd0);
    chk("data_cleared", 64'(if0.rd_data), 64'd0);
    last0 = '0;
    last1 = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    tag = "rst_mid_clear";
    idle_in();
    repeat (10) @(posedge clk);
    #1;
    chk("busy_at10", 64'(if2.busy), 64'd1);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    measure();
    sweep_zero();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_file_mp.md
Name: reg_file_mp

Overview:
Parametrised multi-read-port register file for the RV32I core datapath. It has one write port and NUM_RD synchronous read ports. It adds a hardwired-zero entry 0, an optional write-to-read bypass, and a hardware clear sequencer that zeroes the array one entry per cycle, both after reset and on request. It sits between decode (read addresses) and writeback (write port).

Parameters:
WIDTH, 32, data width of each entry in bits
DEPTH, 32, number of entries (≥2; need not be a power of 2)
ADDR_W, 5, address width; must satisfy 2**ADDR_W ≥ DEPTH
NUM_RD, 2, number of independent read ports (1..4)
ZERO_REG, 1, 1 = entry 0 always reads 0 and ignores writes
BYPASS, 1, 1 = same-cycle write data is forwarded to a matching read

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  reset, asynchronous, active-high
wr_en  in  1  write strobe
wr_addr  in  ADDR_W  write address
wr_data  in  WIDTH  write data
rd_en  in  NUM_RD  per-port read strobe
rd_addr  in  NUM_RD*ADDR_W  packed read addresses; port i uses bits [i*ADDR_W +: ADDR_W]
rd_data  out  NUM_RD*WIDTH  packed registered read data; port i uses bits [i*WIDTH +: WIDTH]
rd_valid  out  NUM_RD  per-port: rd_data for that port is valid this cycle
clr_req  in  1  request a full clear of the array
busy  out  1  clear sequence in progress
clr_done  out  1  one-cycle pulse in the cycle after the last entry is cleared

Behaviour:
- Reset (async assert, held until deasserted):
  - rd_data = 0, rd_valid = 0, clr_done = 0.
  - FSM = CLEAR, clear counter = 0, busy = 1.
  - Array contents are not reset directly; the CLEAR sweep zeroes them.
- FSM states:
  - IDLE: busy = 0. clr_req = 1 → CLEAR next cycle, counter = 0.
  - CLEAR: busy = 1. Each cycle writes 0 to entry[counter], then counter increments. The cycle that writes entry DEPTH-1 → IDLE, and clr_done = 1 on the next cycle.
  - A full sweep takes exactly DEPTH cycles. The counter never exceeds DEPTH-1.
  - clr_req during CLEAR is ignored: no restart, no extension.
- Write port:
  - Commits at the rising edge when wr_en = 1, busy = 0, and wr_addr < DEPTH.
  - Ignored when busy = 1.
  - Ignored when wr_addr ≥ DEPTH.
  - Ignored when ZERO_REG = 1 and wr_addr = 0.
- Read ports, 1-cycle latency:
  - rd_en[i] = 1 at edge N → rd_data[i] and rd_valid[i] = 1 at edge N+1.
  - rd_en[i] = 0 → rd_valid[i] = 0 next cycle; rd_data[i] holds its previous value.
  - Reads while busy = 1: rd_valid[i] = 0 and rd_data[i] holds.
  - Read data is forced to 0 when rd_addr ≥ DEPTH, or when ZERO_REG = 1 and rd_addr = 0.
- Bypass:
  - Applies when BYPASS = 1, rd_en[i] = 1, and a write commits at the same edge to rd_addr[i].
  - rd_data[i] then returns wr_data (new value).
  - BYPASS = 0: the read returns the old array value.
  - Bypass never applies to an ignored write (zero register, out of range, busy).
- Simultaneous events:
  - Any number of ports may read the same address in one cycle; all get identical data.
  - rst asserted mid-CLEAR: counter restarts at 0 and the full sweep repeats after deassert.
  - rst asserted mid-read: rd_valid is cleared immediately.
- Widths: no arithmetic on data. Address compares are unsigned at ADDR_W bits. The counter is ADDR_W bits.

Test Plan:
1. Reset clear
   - Stimulus: defaults (DEPTH=32); pulse rst, then release.
   - Required: busy = 1 for exactly 32 cycles; clr_done pulses once on the cycle busy falls; reading addresses 0..31 then returns 0 with rd_valid = 1.
2. Basic write/read
   - Stimulus: write 0xDEADBEEF to addr 5; next cycle read addr 5 on port 0 and addr 5 on port 1.
   - Required: both ports return 0xDEADBEEF with rd_valid = 11b one cycle later.
3. Zero register
   - Stimulus: write 0x12345678 to addr 0, with a same-cycle read of addr 0.
   - Required: read returns 0 both in the same-cycle (bypass) case and on a later read.
4. Bypass
   - Stimulus: addr 7 holds 0x1; write 0xA5A5A5A5 to addr 7 in the same cycle as a port-1 read of addr 7.
   - Required: BYPASS=1 returns 0xA5A5A5A5; BYPASS=0 returns 0x00000001.
5. Requested clear with blocked traffic
   - Stimulus: fill addr 1..31 with addr*0x11; assert clr_req; during busy, issue a write 0xFF to addr 3 and reads.
   - Required: rd_valid stays 0 while busy; after clr_done, addr 3 reads 0 and all other entries read 0.
6. Out-of-range and reset mid-clear
   - Stimulus A: DEPTH=24; write 0x77 to addr 30, then read addr 30.
   - Required A: read returns 0; no entry changes.
   - Stimulus B: assert rst at clear cycle 10.
   - Required B: after deassert, busy stays high for a fresh 24 cycles.
